// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop counter bank: operating mode encodings.
package tff_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_t;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single T-type flip-flop: toggles on a rising clock edge when t is high, clears under reset.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= q_reg ^ t;
        end
    end

    assign q = q_reg;

endmodule : tff_cell

// File: rtl/tff_counter_bank.sv
// Multi-mode bank of T flip-flops: per-bit toggle, up/down count with modulus and wrap/saturate, clamped load.
module tff_counter_bank
    import tff_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned      SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    mode_t            mode_s;
    logic [WIDTH-1:0] q_cells;
    logic [WIDTH-1:0] inc_tv;
    logic [WIDTH-1:0] dec_tv;
    logic [WIDTH-1:0] tv_next;
    logic             tc_next;
    logic             tc_reg;

    assign mode_s = mode_t'(mode);

    // Ripple-free carry/borrow: a bit flips when every lower bit is all-ones (up) or all-zeros (down).
    generate
        for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign inc_tv[gi] = 1'b1;
                assign dec_tv[gi] = 1'b1;
            end else begin : g_upper
                assign inc_tv[gi] = &q_cells[gi-1:0];
                assign dec_tv[gi] = ~|q_cells[gi-1:0];
            end

            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .t     (tv_next[gi]),
                .q     (q_cells[gi])
            );
        end
    endgenerate

    always_comb begin
        tv_next = '0;
        tc_next = 1'b0;
        if (en) begin
            case (mode_s)
                MODE_TOGGLE: tv_next = t;
                MODE_UP: begin
                    if (q_cells < MAX_VAL) begin
                        tv_next = inc_tv;
                    end else begin
                        // Out-of-range values left by TOGGLE count as sitting at the limit.
                        tv_next = q_cells ^ ((SATURATE != 0) ? MAX_VAL : '0);
                        tc_next = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (q_cells == '0) begin
                        tv_next = q_cells ^ ((SATURATE != 0) ? '0 : MAX_VAL);
                        tc_next = 1'b1;
                    end else if (q_cells > MAX_VAL) begin
                        tv_next = q_cells ^ MAX_VAL;
                    end else begin
                        tv_next = dec_tv;
                    end
                end
                MODE_LOAD: tv_next = q_cells ^ ((t > MAX_VAL) ? MAX_VAL : t);
                default:   tv_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= tc_next;
        end
    end

    assign q  = q_cells;
    assign tc = tc_reg;

endmodule : tff_counter_bank

// File: tb/tb_tff_counter_bank.sv
// Scoreboard bench for tff_counter_bank: three configurations (decade wrap, decade saturate, 8-bit default).
module tb_tff_counter_bank;
    import tff_pkg::*;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] q;
        logic       tc;
    } exp_t;

    logic       clk;
    logic       reset_a, reset_b, reset_c;
    logic       en_a, en_b, en_c;
    logic [1:0] mode_a, mode_b, mode_c;
    logic [3:0] t_a, t_b, q_a, q_b;
    logic [7:0] t_c, q_c;
    logic       tc_a, tc_b, tc_c;

    exp_t  sb[$];
    string names[$];
    int    checks = 0;
    int    errors = 0;

    tff_counter_bank #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .mode(mode_a), .t(t_a), .q(q_a), .tc(tc_a));
    tff_counter_bank #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .mode(mode_b), .t(t_b), .q(q_b), .tc(tc_b));
    tff_counter_bank dut_c (
        .clk(clk), .reset(reset_c), .en(en_c), .mode(mode_c), .t(t_c), .q(q_c), .tc(tc_c));

    always #5 clk = ~clk;

    task automatic expect_now(input logic [1:0] id, input logic [7:0] eq, input logic etc,
                              input string nm);
        exp_t e;
        e.id = id;
        e.q  = eq;
        e.tc = etc;
        sb.push_back(e);
        names.push_back(nm);
    endtask

    // One transaction on one instance; the others are held with en=0.
    task automatic step(input logic [1:0] id, input logic [1:0] m, input logic e,
                        input logic [7:0] tv, input logic [7:0] eq, input logic etc,
                        input string nm);
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
        case (id)
            2'd0: begin en_a = e; mode_a = m; t_a = tv[3:0]; end
            2'd1: begin en_b = e; mode_b = m; t_b = tv[3:0]; end
            default: begin en_c = e; mode_c = m; t_c = tv; end
        endcase
        @(posedge clk);
        expect_now(id, eq, etc, nm);
        @(negedge clk);
        #1;
    endtask

    // Monitor: outputs are stable at the falling edge; compare against every queued expectation.
    initial begin
        exp_t       e;
        string      nm;
        logic [7:0] aq;
        logic       atc;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e  = sb.pop_front();
                nm = names.pop_front();
                case (e.id)
                    2'd0:    begin aq = {4'b0, q_a}; atc = tc_a; end
                    2'd1:    begin aq = {4'b0, q_b}; atc = tc_b; end
                    default: begin aq = q_c;         atc = tc_c; end
                endcase
                checks++;
                if (aq !== e.q || atc !== e.tc) begin
                    errors++;
                    $display("FAIL %s (dut %0d): got q=%0h tc=%0b, expected q=%0h tc=%0b",
                             nm, e.id, aq, atc, e.q, e.tc);
                end else begin
                    $display("check %s (dut %0d): q=%0h tc=%0b ok", nm, e.id, aq, atc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        mode_a = MODE_TOGGLE; mode_b = MODE_TOGGLE; mode_c = MODE_TOGGLE;
        t_a = '0; t_b = '0; t_c = '0;

        expect_now(2'd0, 8'h00, 1'b0, "reset_state");
        expect_now(2'd1, 8'h00, 1'b0, "reset_state");
        expect_now(2'd2, 8'h00, 1'b0, "reset_state");
        @(negedge clk);
        #1;
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;

        // Asynchronous reset mid-period with q=5, then first UP after release.
        step(2'd0, MODE_LOAD, 1'b1, 8'h05, 8'h05, 1'b0, "load5");
        @(posedge clk);
        #2;
        reset_a = 1'b0;
        expect_now(2'd0, 8'h00, 1'b0, "async_reset");
        @(negedge clk);
        #1;
        step(2'd0, MODE_UP, 1'b1, 8'h00, 8'h00, 1'b0, "reset_held");
        reset_a = 1'b1;
        step(2'd0, MODE_UP, 1'b1, 8'h00, 8'h01, 1'b0, "first_up");

        // Decade wrap.
        step(2'd0, MODE_LOAD, 1'b1, 8'h00, 8'h00, 1'b0, "load0");
        for (int i = 1; i <= 12; i++) begin
            step(2'd0, MODE_UP, 1'b1, 8'h00, 8'(i % 10), (i == 10), "decade_up");
        end

        // Load clamp and hold.
        step(2'd0, MODE_LOAD, 1'b1, 8'h0C, 8'h09, 1'b0, "load_clamp");
        step(2'd0, MODE_LOAD, 1'b1, 8'h03, 8'h03, 1'b0, "load3");
        for (int i = 0; i < 3; i++) begin
            step(2'd0, MODE_UP, 1'b0, 8'h00, 8'h03, 1'b0, "hold_en0");
        end

        // Toggle into out-of-range values.
        step(2'd0, MODE_LOAD, 1'b1, 8'h00, 8'h00, 1'b0, "load0");
        step(2'd0, MODE_TOGGLE, 1'b1, 8'h0A, 8'h0A, 1'b0, "toggle_a");
        step(2'd0, MODE_UP, 1'b1, 8'h00, 8'h00, 1'b1, "up_out_of_range");
        step(2'd0, MODE_TOGGLE, 1'b1, 8'h0A, 8'h0A, 1'b0, "toggle_a2");
        step(2'd0, MODE_DOWN, 1'b1, 8'h00, 8'h09, 1'b0, "down_out_of_range");

        // Saturating instance.
        step(2'd1, MODE_LOAD, 1'b1, 8'h02, 8'h02, 1'b0, "sat_load2");
        step(2'd1, MODE_DOWN, 1'b1, 8'h00, 8'h01, 1'b0, "sat_down");
        step(2'd1, MODE_DOWN, 1'b1, 8'h00, 8'h00, 1'b0, "sat_down");
        step(2'd1, MODE_DOWN, 1'b1, 8'h00, 8'h00, 1'b1, "sat_down_limit");
        step(2'd1, MODE_DOWN, 1'b1, 8'h00, 8'h00, 1'b1, "sat_down_limit");
        step(2'd1, MODE_LOAD, 1'b1, 8'h08, 8'h08, 1'b0, "sat_load8");
        step(2'd1, MODE_UP, 1'b1, 8'h00, 8'h09, 1'b0, "sat_up");
        step(2'd1, MODE_UP, 1'b1, 8'h00, 8'h09, 1'b1, "sat_up_limit");
        step(2'd1, MODE_UP, 1'b1, 8'h00, 8'h09, 1'b1, "sat_up_limit");

        // Full-range 8-bit instance.
        step(2'd2, MODE_LOAD, 1'b1, 8'hFF, 8'hFF, 1'b0, "full_loadff");
        step(2'd2, MODE_UP, 1'b1, 8'h00, 8'h00, 1'b1, "full_up_wrap");
        step(2'd2, MODE_DOWN, 1'b1, 8'h00, 8'hFF, 1'b1, "full_down_wrap");
        step(2'd2, MODE_LOAD, 1'b1, 8'h05, 8'h05, 1'b0, "full_load5");
        step(2'd2, MODE_UP, 1'b1, 8'h00, 8'h06, 1'b0, "full_up");
        step(2'd2, MODE_DOWN, 1'b1, 8'h00, 8'h05, 1'b0, "full_down");
        step(2'd2, MODE_TOGGLE, 1'b1, 8'hA5, 8'hA0, 1'b0, "full_toggle");

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tff_counter_bank

// File: doc/tff_counter_bank.md
Name: tff_counter_bank

Overview:
- Parametrised, multi-mode register bank built from WIDTH T-type flip-flop cells. It is the multi-bit successor of the team's single-bit asynchronous-reset T flip-flop.
- Supports four modes: per-bit toggle, synchronous up-count, synchronous down-count and parallel load.
- Up/down counting has a programmable modulus and a wrap or saturate policy.
- Used as a general counter/divider primitive in later designs, for example decade counters and clock-enable dividers.

Parameters:
- WIDTH, 8, number of T-FF cells / bits of q (1..32).
- MAX_VAL, 2**WIDTH-1, highest count value in count modes; must be ≤ 2**WIDTH-1 and ≥ 1.
- SATURATE, 0, 0 = wrap at the count limits, 1 = hold at the limit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  update enable; 0 = hold q.
- mode  input  2  00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD.
- t  input  WIDTH  toggle mask in TOGGLE; load data in LOAD; ignored otherwise.
- q  output  WIDTH  registered bank state.
- tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset:
  - reset=0 immediately, independent of clk, forces q=0 and tc=0.
  - Both hold while reset=0.
  - First update occurs on the first rising clk edge after reset returns to 1.
  - Reset mid-count aborts the count; no tc is produced for an aborted cycle.
- All updates happen on the rising clk edge. Latency is one cycle from inputs to q/tc.
- en=0: q holds; tc=0 on that edge.
- TOGGLE (en=1):
  - q <= q ^ t, i.e. bit i toggles when t[i]=1 (exact single-bit T-FF semantics per bit).
  - No MAX_VAL range check.
  - tc <= 0.
- UP (en=1):
  - If q < MAX_VAL: q <= q+1, tc <= 0.
  - If q ≥ MAX_VAL: q <= 0 when SATURATE=0, or q <= MAX_VAL when SATURATE=1; tc <= 1 in both cases.
  - So tc is high in the cycle following the limit edge, for one cycle unless the limit persists.
  - An out-of-range q (reachable only via TOGGLE) is treated as being at the limit.
- DOWN (en=1):
  - If q > 0 and q ≤ MAX_VAL: q <= q-1, tc <= 0.
  - If q == 0: q <= MAX_VAL when SATURATE=0, or q <= 0 when SATURATE=1; tc <= 1.
  - If q > MAX_VAL: q <= MAX_VAL, tc <= 0.
- LOAD (en=1):
  - q <= min(t, MAX_VAL); tc <= 0.
- SATURATE=1 while sitting at the limit with the count mode unchanged: tc stays 1 on every enabled edge.
- Mode change takes effect on the same edge it is sampled. There is no pipeline and no internal state beyond q and tc.
- Arithmetic:
  - All comparisons are unsigned, WIDTH bits.
  - When MAX_VAL = 2**WIDTH-1, the wrap equals natural modulo arithmetic.
- Implementation rule: every bit of q is held in one tff_cell. Next state is expressed as the toggle vector tv = q ^ q_next:
  - UP, no wrap: tv[i] = &q[i-1:0].
  - DOWN, no wrap: tv[i] = &~q[i-1:0].
  - Wrap, saturate and LOAD: tv = q ^ target.
  - TOGGLE: tv = t.
  - en=0: tv = 0.

Decomposition:
- Shared package tff_pkg holds:
  - the mode encodings MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11;
  - a 2-bit mode typedef.
- One sub-module, tff_cell:
  - ports clk, reset (async active-low), t, q;
  - instantiated WIDTH times via generate;
  - behaviour: q <= q ^ t on the clock edge, q = 0 under reset.
- tc register and toggle-vector logic live in the top.

Test Plan:
- Reset: drive reset=0 mid-clock-period with q=4'h5. Required: q=0 and tc=0 before the next edge. Release reset; the first UP edge gives q=1.
- Decade wrap (WIDTH=4, MAX_VAL=9, SATURATE=0): UP for 12 enabled edges from 0. Required: q sequence 1..9,0,1,2; tc=1 only in the cycle where q became 0.
- Saturate (WIDTH=4, MAX_VAL=9, SATURATE=1):
  - DOWN from q=2 for 4 edges gives q=1,0,0,0, with tc=1 in the last two cycles.
  - UP from q=8 for 3 edges gives q=9,9,9, with tc=0,1,1.
- Load clamp (MAX_VAL=9): LOAD t=4'hC gives q=9. LOAD t=4'h3 gives q=3. Then en=0 for 3 edges: q stays 3, tc=0.
- Toggle and out-of-range (MAX_VAL=9):
  - From q=0, TOGGLE t=4'b1010 gives q=4'hA.
  - UP then gives q=0 with tc=1 (out-of-range treated as limit).
  - From q=4'hA, DOWN gives q=9 with tc=0.
- Full-range wrap (WIDTH=8, defaults):
  - From q=8'hFF, UP gives q=8'h00 and tc=1.
  - From q=8'h00, DOWN gives q=8'hFF and tc=1.
  - Mode switch UP→DOWN on consecutive edges from 5 gives 6 then 5.
